// File: rtl/diff_commit_collector_pkg.sv
// Shared difftest definitions: lane count, store-valid bit map and the per-slot
// commit record produced by the ROB commit stage.
package diff_commit_collector_pkg;

  localparam int LANES = 3;

  localparam int SV_B  = 0;
  localparam int SV_H  = 1;
  localparam int SV_W  = 2;
  localparam int SV_SC = 3;

  localparam logic [1:0] ST_SIZE_B = 2'd0;
  localparam logic [1:0] ST_SIZE_H = 2'd1;
  localparam logic [1:0] ST_SIZE_W = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] wdata;
    logic        skip;
    logic        tlbfill;
    logic        cnt;
    logic        csr_rstat;
    logic [4:0]  tlbfill_idx;
    logic [63:0] timer;
    logic [31:0] csr_data;
  } commit_rec_t;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Reserved size encoding 3 reports no access-width bit.
  function automatic logic [7:0] store_valid_enc(input logic valid, input logic [1:0] size,
                                                 input logic sc);
    logic [7:0] v;
    v = 8'd0;
    if (valid) begin
      case (size)
        ST_SIZE_B: v[SV_B] = 1'b1;
        ST_SIZE_H: v[SV_H] = 1'b1;
        ST_SIZE_W: v[SV_W] = 1'b1;
        default:   v = 8'd0;
      endcase
      v[SV_SC] = sc;
    end else begin
      v = 8'd0;
    end
    return v;
  endfunction

endpackage

// File: rtl/diff_commit_collector_compactor.sv
// Packs valid commit slots into the lowest lanes in ascending slot order;
// lanes left over are fully zeroed.
module diff_lane_compactor
  import diff_commit_collector_pkg::*;
(
  input  logic [LANES-1:0] slot_valid,
  input  commit_rec_t      slot [LANES],
  output logic [LANES-1:0] lane_valid,
  output commit_rec_t      lane [LANES]
);

  logic [1:0] fill_s;

  // Walk slots in order, dropping each valid one into the next free lane.
  always_comb begin
    lane_valid = '0;
    fill_s     = 2'd0;
    for (int l = 0; l < LANES; l++) lane[l] = '0;
    for (int i = 0; i < LANES; i++) begin
      if (slot_valid[i]) begin
        lane[fill_s]       = slot[i];
        lane_valid[fill_s] = 1'b1;
        fill_s             = fill_s + 2'd1;
      end else begin
        fill_s = fill_s;
      end
    end
  end

endmodule

// File: rtl/diff_commit_collector.sv
// Difftest producer: registers compacted commit lanes, store and exception
// records for the bridge, and tracks instret plus a no-progress watchdog.
module diff_commit_collector
  import diff_commit_collector_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int HANG_CYCLES = 5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  cm_valid,
  input  logic [31:0]       cm_pc_0, cm_pc_1, cm_pc_2,
  input  logic [31:0]       cm_instr_0, cm_instr_1, cm_instr_2,
  input  logic              cm_wen_0, cm_wen_1, cm_wen_2,
  input  logic [4:0]        cm_wdest_0, cm_wdest_1, cm_wdest_2,
  input  logic [31:0]       cm_wdata_0, cm_wdata_1, cm_wdata_2,
  input  logic              cm_skip_0, cm_skip_1, cm_skip_2,
  input  logic              cm_tlbfill_0, cm_tlbfill_1, cm_tlbfill_2,
  input  logic              cm_cnt_0, cm_cnt_1, cm_cnt_2,
  input  logic              cm_csr_rstat_0, cm_csr_rstat_1, cm_csr_rstat_2,
  input  logic [4:0]        cm_tlbfill_idx_0, cm_tlbfill_idx_1, cm_tlbfill_idx_2,
  input  logic [63:0]       cm_timer_0, cm_timer_1, cm_timer_2,
  input  logic [31:0]       cm_csr_data_0, cm_csr_data_1, cm_csr_data_2,
  input  logic              st_valid,
  input  logic [1:0]        st_size,
  input  logic              st_sc,
  input  logic [31:0]       st_paddr, st_vaddr, st_data,
  input  logic              ex_valid,
  input  logic              ex_eret,
  input  logic [5:0]        ex_ecode,
  input  logic [10:0]       ex_intr,
  input  logic [31:0]       ex_pc, ex_inst,
  output logic [7:0]        index_0, index_1, index_2,
  output logic              Instrvalid_0, Instrvalid_1, Instrvalid_2,
  output logic [63:0]       the_pc_0, the_pc_1, the_pc_2,
  output logic [31:0]       instr_0, instr_1, instr_2,
  output logic              skip_0, skip_1, skip_2,
  output logic              is_TLBFILL_0, is_TLBFILL_1, is_TLBFILL_2,
  output logic              is_CNTinst_0, is_CNTinst_1, is_CNTinst_2,
  output logic              wen_0, wen_1, wen_2,
  output logic              csr_rstat_0, csr_rstat_1, csr_rstat_2,
  output logic [4:0]        TLBFILL_index_0, TLBFILL_index_1, TLBFILL_index_2,
  output logic [63:0]       timer_64_value_0, timer_64_value_1, timer_64_value_2,
  output logic [7:0]        wdest_0, wdest_1, wdest_2,
  output logic [63:0]       wdata_0, wdata_1, wdata_2,
  output logic [31:0]       csr_data_0, csr_data_1, csr_data_2,
  output logic [7:0]        storeIndex,
  output logic [7:0]        storeValid,
  output logic [63:0]       storePaddr, storeVaddr, storeData,
  output logic              excp_valid,
  output logic              eret,
  output logic [10:0]       intrNo,
  output logic [5:0]        cause,
  output logic [31:0]       exceptionPC, exceptionInst,
  output logic [63:0]       instret,
  output logic              hang
);

  localparam int CW = $clog2(HANG_CYCLES + 1);
  localparam logic [CW-1:0] HANG_LIM = CW'(HANG_CYCLES);

  commit_rec_t      slot_s [WIDTH];
  commit_rec_t      lane_s [WIDTH];
  commit_rec_t      lane_r [WIDTH];
  logic [WIDTH-1:0] lane_valid_s, lane_valid_r;
  logic             idx_live_r;
  logic [31:0]      st_paddr_r, st_vaddr_r, st_data_r;
  logic [CW-1:0]    idle_cnt_r, idle_next_s;
  logic             idle_s;

  // An r0 destination is folded into wen here so the lanes never report it as a write.
  assign slot_s[0] = '{cm_pc_0, cm_instr_0, cm_wen_0 & (cm_wdest_0 != 5'd0), cm_wdest_0,
                       cm_wdata_0, cm_skip_0, cm_tlbfill_0, cm_cnt_0, cm_csr_rstat_0,
                       cm_tlbfill_idx_0, cm_timer_0, cm_csr_data_0};
  assign slot_s[1] = '{cm_pc_1, cm_instr_1, cm_wen_1 & (cm_wdest_1 != 5'd0), cm_wdest_1,
                       cm_wdata_1, cm_skip_1, cm_tlbfill_1, cm_cnt_1, cm_csr_rstat_1,
                       cm_tlbfill_idx_1, cm_timer_1, cm_csr_data_1};
  assign slot_s[2] = '{cm_pc_2, cm_instr_2, cm_wen_2 & (cm_wdest_2 != 5'd0), cm_wdest_2,
                       cm_wdata_2, cm_skip_2, cm_tlbfill_2, cm_cnt_2, cm_csr_rstat_2,
                       cm_tlbfill_idx_2, cm_timer_2, cm_csr_data_2};

  diff_lane_compactor u_compactor (
    .slot_valid (cm_valid),
    .slot       (slot_s),
    .lane_valid (lane_valid_s),
    .lane       (lane_s)
  );

  // Capture compacted commit lanes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < WIDTH; k++) lane_r[k] <= '0;
      lane_valid_r <= '0;
      idx_live_r   <= 1'b0;
    end else begin
      for (int k = 0; k < WIDTH; k++) lane_r[k] <= lane_s[k];
      lane_valid_r <= lane_valid_s;
      idx_live_r   <= 1'b1;
    end
  end

  // Capture store and exception records; fields are zeroed when their valid is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      storeValid <= 8'd0; st_paddr_r <= 32'd0; st_vaddr_r <= 32'd0; st_data_r <= 32'd0;
      excp_valid <= 1'b0; eret <= 1'b0; intrNo <= 11'd0; cause <= 6'd0;
      exceptionPC <= 32'd0; exceptionInst <= 32'd0;
    end else begin
      storeValid <= store_valid_enc(st_valid, st_size, st_sc);
      st_paddr_r <= st_valid ? st_paddr : 32'd0;
      st_vaddr_r <= st_valid ? st_vaddr : 32'd0;
      st_data_r  <= st_valid ? st_data  : 32'd0;
      excp_valid    <= ex_valid;
      eret          <= ex_valid ? ex_eret  : 1'b0;
      intrNo        <= ex_valid ? ex_intr  : 11'd0;
      cause         <= ex_valid ? ex_ecode : 6'd0;
      exceptionPC   <= ex_valid ? ex_pc    : 32'd0;
      exceptionInst <= ex_valid ? ex_inst  : 32'd0;
    end
  end

  // Idle counter saturates at the limit so hang cannot be missed by wrap-around.
  always_comb begin
    idle_s = (cm_valid == 3'd0) && !ex_valid;
    if (!idle_s) begin
      idle_next_s = '0;
    end else if (idle_cnt_r == HANG_LIM) begin
      idle_next_s = idle_cnt_r;
    end else begin
      idle_next_s = idle_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Retired-instruction count and sticky watchdog flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instret    <= 64'd0;
      idle_cnt_r <= '0;
      hang       <= 1'b0;
    end else begin
      instret    <= instret + {62'd0, popcount3(cm_valid)};
      idle_cnt_r <= idle_next_s;
      hang       <= hang | (idle_next_s == HANG_LIM);
    end
  end

  assign index_0 = 8'd0;
  assign index_1 = {7'd0, idx_live_r};
  assign index_2 = {6'd0, idx_live_r, 1'b0};

  assign storeIndex = 8'd0;
  assign storePaddr = {32'd0, st_paddr_r};
  assign storeVaddr = {32'd0, st_vaddr_r};
  assign storeData  = {32'd0, st_data_r};

  assign {Instrvalid_2, Instrvalid_1, Instrvalid_0} = lane_valid_r;
  assign the_pc_0 = {32'd0, lane_r[0].pc};  assign instr_0 = lane_r[0].instr;
  assign the_pc_1 = {32'd0, lane_r[1].pc};  assign instr_1 = lane_r[1].instr;
  assign the_pc_2 = {32'd0, lane_r[2].pc};  assign instr_2 = lane_r[2].instr;
  assign skip_0 = lane_r[0].skip;  assign is_TLBFILL_0 = lane_r[0].tlbfill;
  assign skip_1 = lane_r[1].skip;  assign is_TLBFILL_1 = lane_r[1].tlbfill;
  assign skip_2 = lane_r[2].skip;  assign is_TLBFILL_2 = lane_r[2].tlbfill;
  assign is_CNTinst_0 = lane_r[0].cnt;  assign csr_rstat_0 = lane_r[0].csr_rstat;
  assign is_CNTinst_1 = lane_r[1].cnt;  assign csr_rstat_1 = lane_r[1].csr_rstat;
  assign is_CNTinst_2 = lane_r[2].cnt;  assign csr_rstat_2 = lane_r[2].csr_rstat;
  assign wen_0 = lane_r[0].wen;  assign wdest_0 = {3'd0, lane_r[0].wdest};
  assign wen_1 = lane_r[1].wen;  assign wdest_1 = {3'd0, lane_r[1].wdest};
  assign wen_2 = lane_r[2].wen;  assign wdest_2 = {3'd0, lane_r[2].wdest};
  assign wdata_0 = {32'd0, lane_r[0].wdata};  assign csr_data_0 = lane_r[0].csr_data;
  assign wdata_1 = {32'd0, lane_r[1].wdata};  assign csr_data_1 = lane_r[1].csr_data;
  assign wdata_2 = {32'd0, lane_r[2].wdata};  assign csr_data_2 = lane_r[2].csr_data;
  assign TLBFILL_index_0 = lane_r[0].tlbfill_idx;  assign timer_64_value_0 = lane_r[0].timer;
  assign TLBFILL_index_1 = lane_r[1].tlbfill_idx;  assign timer_64_value_1 = lane_r[1].timer;
  assign TLBFILL_index_2 = lane_r[2].tlbfill_idx;  assign timer_64_value_2 = lane_r[2].timer;

endmodule

// File: tb/tb_diff_commit_collector.sv
// Directed bench for diff_commit_collector: vector table for lane/store/exception
// encoding, then hand sequences for full field capture, watchdog and reset.
module tb_diff_commit_collector;

  localparam logic [63:0] P0 = 64'h1c000000;
  localparam logic [63:0] P1 = 64'h1c000004;
  localparam logic [63:0] P2 = 64'h1c000008;

  logic        clock, reset;
  logic [2:0]  cm_valid;
  logic [31:0] cm_pc [3], cm_instr [3], cm_wdata [3], cm_csr_data [3];
  logic        cm_wen [3], cm_skip [3], cm_tlbfill [3], cm_cnt [3], cm_csr_rstat [3];
  logic [4:0]  cm_wdest [3], cm_tlbfill_idx [3];
  logic [63:0] cm_timer [3];
  logic        st_valid, st_sc, ex_valid, ex_eret;
  logic [1:0]  st_size;
  logic [31:0] st_paddr, st_vaddr, st_data, ex_pc, ex_inst;
  logic [5:0]  ex_ecode;
  logic [10:0] ex_intr;

  logic [7:0]  idx [3], wdest [3];
  logic        ivld [3], skip [3], tlbf [3], cnt [3], wen [3], rstat [3];
  logic [63:0] pc [3], timer [3], wdata [3];
  logic [31:0] instr [3], csrd [3];
  logic [4:0]  tlbidx [3];
  logic [7:0]  storeIndex, storeValid;
  logic [63:0] storePaddr, storeVaddr, storeData, instret;
  logic        excp_valid, eret, hang;
  logic [10:0] intrNo;
  logic [5:0]  cause;
  logic [31:0] exceptionPC, exceptionInst;

  diff_commit_collector #(.WIDTH(3), .HANG_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .cm_valid(cm_valid),
    .cm_pc_0(cm_pc[0]), .cm_pc_1(cm_pc[1]), .cm_pc_2(cm_pc[2]),
    .cm_instr_0(cm_instr[0]), .cm_instr_1(cm_instr[1]), .cm_instr_2(cm_instr[2]),
    .cm_wen_0(cm_wen[0]), .cm_wen_1(cm_wen[1]), .cm_wen_2(cm_wen[2]),
    .cm_wdest_0(cm_wdest[0]), .cm_wdest_1(cm_wdest[1]), .cm_wdest_2(cm_wdest[2]),
    .cm_wdata_0(cm_wdata[0]), .cm_wdata_1(cm_wdata[1]), .cm_wdata_2(cm_wdata[2]),
    .cm_skip_0(cm_skip[0]), .cm_skip_1(cm_skip[1]), .cm_skip_2(cm_skip[2]),
    .cm_tlbfill_0(cm_tlbfill[0]), .cm_tlbfill_1(cm_tlbfill[1]), .cm_tlbfill_2(cm_tlbfill[2]),
    .cm_cnt_0(cm_cnt[0]), .cm_cnt_1(cm_cnt[1]), .cm_cnt_2(cm_cnt[2]),
    .cm_csr_rstat_0(cm_csr_rstat[0]), .cm_csr_rstat_1(cm_csr_rstat[1]),
    .cm_csr_rstat_2(cm_csr_rstat[2]),
    .cm_tlbfill_idx_0(cm_tlbfill_idx[0]), .cm_tlbfill_idx_1(cm_tlbfill_idx[1]),
    .cm_tlbfill_idx_2(cm_tlbfill_idx[2]),
    .cm_timer_0(cm_timer[0]), .cm_timer_1(cm_timer[1]), .cm_timer_2(cm_timer[2]),
    .cm_csr_data_0(cm_csr_data[0]), .cm_csr_data_1(cm_csr_data[1]),
    .cm_csr_data_2(cm_csr_data[2]),
    .st_valid(st_valid), .st_size(st_size), .st_sc(st_sc),
    .st_paddr(st_paddr), .st_vaddr(st_vaddr), .st_data(st_data),
    .ex_valid(ex_valid), .ex_eret(ex_eret), .ex_ecode(ex_ecode), .ex_intr(ex_intr),
    .ex_pc(ex_pc), .ex_inst(ex_inst),
    .index_0(idx[0]), .index_1(idx[1]), .index_2(idx[2]),
    .Instrvalid_0(ivld[0]), .Instrvalid_1(ivld[1]), .Instrvalid_2(ivld[2]),
    .the_pc_0(pc[0]), .the_pc_1(pc[1]), .the_pc_2(pc[2]),
    .instr_0(instr[0]), .instr_1(instr[1]), .instr_2(instr[2]),
    .skip_0(skip[0]), .skip_1(skip[1]), .skip_2(skip[2]),
    .is_TLBFILL_0(tlbf[0]), .is_TLBFILL_1(tlbf[1]), .is_TLBFILL_2(tlbf[2]),
    .is_CNTinst_0(cnt[0]), .is_CNTinst_1(cnt[1]), .is_CNTinst_2(cnt[2]),
    .wen_0(wen[0]), .wen_1(wen[1]), .wen_2(wen[2]),
    .csr_rstat_0(rstat[0]), .csr_rstat_1(rstat[1]), .csr_rstat_2(rstat[2]),
    .TLBFILL_index_0(tlbidx[0]), .TLBFILL_index_1(tlbidx[1]), .TLBFILL_index_2(tlbidx[2]),
    .timer_64_value_0(timer[0]), .timer_64_value_1(timer[1]), .timer_64_value_2(timer[2]),
    .wdest_0(wdest[0]), .wdest_1(wdest[1]), .wdest_2(wdest[2]),
    .wdata_0(wdata[0]), .wdata_1(wdata[1]), .wdata_2(wdata[2]),
    .csr_data_0(csrd[0]), .csr_data_1(csrd[1]), .csr_data_2(csrd[2]),
    .storeIndex(storeIndex), .storeValid(storeValid), .storePaddr(storePaddr),
    .storeVaddr(storeVaddr), .storeData(storeData),
    .excp_valid(excp_valid), .eret(eret), .intrNo(intrNo), .cause(cause),
    .exceptionPC(exceptionPC), .exceptionInst(exceptionInst),
    .instret(instret), .hang(hang)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  cm;
    logic        wen0;
    logic [4:0]  wdest0;
    logic [31:0] wdata0;
    logic        stv;
    logic [1:0]  sts;
    logic        stsc;
    logic        exv;
    logic [5:0]  ecode;
    logic [2:0]  e_ivld;
    logic [63:0] e_pc0, e_pc1, e_pc2;
    logic        e_wen0;
    logic [7:0]  e_wdest0;
    logic [63:0] e_wdata0;
    logic [7:0]  e_stv;
    logic        e_excp;
    logic [5:0]  e_cause;
    logic [1:0]  e_dinst;
  } vec_t;

  vec_t        vecs [12];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [63:0] exp_instret;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cm_valid = 3'b000; st_valid = 1'b0; ex_valid = 1'b0;
  endtask

  initial begin
    // slot 1 and 2 carry fixed writeback data; slot 2 targets r0
    for (int i = 0; i < 3; i++) begin
      cm_pc[i] = 32'h1c000000 + 32'(4 * i);
      cm_instr[i] = 32'h02800000 + 32'(i);
      cm_skip[i] = 1'b0; cm_tlbfill[i] = 1'b0; cm_cnt[i] = 1'b0; cm_csr_rstat[i] = 1'b0;
      cm_tlbfill_idx[i] = 5'd0; cm_timer[i] = 64'd0; cm_csr_data[i] = 32'd0;
    end
    cm_wen[0] = 1'b0; cm_wdest[0] = 5'd0;  cm_wdata[0] = 32'd0;
    cm_wen[1] = 1'b1; cm_wdest[1] = 5'd7;  cm_wdata[1] = 32'h11111111;
    cm_wen[2] = 1'b1; cm_wdest[2] = 5'd0;  cm_wdata[2] = 32'h22222222;
    st_size = 2'd0; st_sc = 1'b0; st_paddr = 32'h00001000; st_vaddr = 32'h80001000;
    st_data = 32'hcafef00d; ex_eret = 1'b0; ex_ecode = 6'd0; ex_intr = 11'd0;
    ex_pc = 32'h1c000100; ex_inst = 32'h002b0000;
    idle_inputs();

    vecs[0]  = '{3'b101, 1'b0, 5'd0,  32'h0,        1'b0, 2'd0, 1'b0, 1'b0, 6'h00,
                 3'b011, P0, P2, 64'd0, 1'b0, 8'h00, 64'h0,        8'h00, 1'b0, 6'h00, 2'd2};
    vecs[1]  = '{3'b001, 1'b1, 5'd0,  32'hdeadbeef, 1'b0, 2'd0, 1'b0, 1'b0, 6'h00,
                 3'b001, P0, 64'd0, 64'd0, 1'b0, 8'h00, 64'hdeadbeef, 8'h00, 1'b0, 6'h00, 2'd1};
    vecs[2]  = '{3'b001, 1'b1, 5'd5,  32'hdeadbeef, 1'b0, 2'd0, 1'b0, 1'b0, 6'h00,
                 3'b001, P0, 64'd0, 64'd0, 1'b1, 8'h05, 64'hdeadbeef, 8'h00, 1'b0, 6'h00, 2'd1};
    vecs[3]  = '{3'b110, 1'b1, 5'd5,  32'hdeadbeef, 1'b0, 2'd0, 1'b0, 1'b0, 6'h00,
                 3'b011, P1, P2, 64'd0, 1'b1, 8'h07, 64'h11111111, 8'h00, 1'b0, 6'h00, 2'd2};
    vecs[4]  = '{3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 2'd2, 1'b1, 1'b0, 6'h00,
                 3'b000, 64'd0, 64'd0, 64'd0, 1'b0, 8'h00, 64'h0,   8'h0c, 1'b0, 6'h00, 2'd0};
    vecs[5]  = '{3'b111, 1'b1, 5'd3,  32'h00000abc, 1'b1, 2'd0, 1'b0, 1'b0, 6'h00,
                 3'b111, P0, P1, P2, 1'b1, 8'h03, 64'h00000abc,     8'h01, 1'b0, 6'h00, 2'd3};
    vecs[6]  = '{3'b001, 1'b0, 5'd0,  32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 6'h0b,
                 3'b001, P0, 64'd0, 64'd0, 1'b0, 8'h00, 64'h0,      8'h00, 1'b1, 6'h0b, 2'd1};
    vecs[7]  = '{3'b010, 1'b0, 5'd0,  32'h0,        1'b1, 2'd1, 1'b0, 1'b1, 6'h3f,
                 3'b001, P1, 64'd0, 64'd0, 1'b1, 8'h07, 64'h11111111, 8'h02, 1'b1, 6'h3f, 2'd1};
    vecs[8]  = '{3'b100, 1'b0, 5'd0,  32'h0,        1'b0, 2'd2, 1'b1, 1'b0, 6'h00,
                 3'b001, P2, 64'd0, 64'd0, 1'b0, 8'h00, 64'h22222222, 8'h00, 1'b0, 6'h00, 2'd1};
    vecs[9]  = '{3'b011, 1'b1, 5'd31, 32'hffffffff, 1'b1, 2'd3, 1'b0, 1'b0, 6'h00,
                 3'b011, P0, P1, 64'd0, 1'b1, 8'h1f, 64'hffffffff,  8'h00, 1'b0, 6'h00, 2'd2};
    vecs[10] = '{3'b000, 1'b0, 5'd0,  32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 6'h00,
                 3'b000, 64'd0, 64'd0, 64'd0, 1'b0, 8'h00, 64'h0,   8'h00, 1'b1, 6'h00, 2'd0};
    vecs[11] = '{3'b111, 1'b0, 5'd0,  32'h0,        1'b1, 2'd2, 1'b0, 1'b0, 6'h00,
                 3'b111, P0, P1, P2, 1'b0, 8'h00, 64'h0,            8'h04, 1'b0, 6'h00, 2'd3};

    // Reset held: every output is zero, including the lane indices.
    reset = 1'b0;
    tick(); tick();
    chk("rst_instret", instret, 64'd0);
    chk("rst_index1", {56'd0, idx[1]}, 64'd0);
    chk("rst_index2", {56'd0, idx[2]}, 64'd0);
    chk("rst_hang", {63'd0, hang}, 64'd0);
    @(negedge clock); reset = 1'b1;
    tick();
    chk("index0", {56'd0, idx[0]}, 64'd0);
    chk("index1", {56'd0, idx[1]}, 64'd1);
    chk("index2", {56'd0, idx[2]}, 64'd2);
    exp_instret = 64'd0;

    for (int v = 0; v < 12; v++) begin
      cm_valid = vecs[v].cm; cm_wen[0] = vecs[v].wen0; cm_wdest[0] = vecs[v].wdest0;
      cm_wdata[0] = vecs[v].wdata0; st_valid = vecs[v].stv; st_size = vecs[v].sts;
      st_sc = vecs[v].stsc; ex_valid = vecs[v].exv; ex_ecode = vecs[v].ecode;
      tick();
      exp_instret = exp_instret + {62'd0, vecs[v].e_dinst};
      chk($sformatf("v%0d_ivalid", v), {61'd0, ivld[2], ivld[1], ivld[0]}, {61'd0, vecs[v].e_ivld});
      chk($sformatf("v%0d_pc0", v), pc[0], vecs[v].e_pc0);
      chk($sformatf("v%0d_pc1", v), pc[1], vecs[v].e_pc1);
      chk($sformatf("v%0d_pc2", v), pc[2], vecs[v].e_pc2);
      chk($sformatf("v%0d_wen0", v), {63'd0, wen[0]}, {63'd0, vecs[v].e_wen0});
      chk($sformatf("v%0d_wdest0", v), {56'd0, wdest[0]}, {56'd0, vecs[v].e_wdest0});
      chk($sformatf("v%0d_wdata0", v), wdata[0], vecs[v].e_wdata0);
      chk($sformatf("v%0d_storeValid", v), {56'd0, storeValid}, {56'd0, vecs[v].e_stv});
      chk($sformatf("v%0d_excp", v), {63'd0, excp_valid}, {63'd0, vecs[v].e_excp});
      chk($sformatf("v%0d_cause", v), {58'd0, cause}, {58'd0, vecs[v].e_cause});
      chk($sformatf("v%0d_instret", v), instret, exp_instret);
    end

    // Every lane-0, store and exception field captured, then gone one cycle later.
    cm_valid = 3'b010; cm_instr[1] = 32'h12345678; cm_skip[1] = 1'b1; cm_tlbfill[1] = 1'b1;
    cm_cnt[1] = 1'b1; cm_csr_rstat[1] = 1'b1; cm_tlbfill_idx[1] = 5'd19;
    cm_timer[1] = 64'hfedcba9876543210; cm_csr_data[1] = 32'h0badf00d;
    st_valid = 1'b1; st_size = 2'd1; st_sc = 1'b0;
    ex_valid = 1'b1; ex_eret = 1'b1; ex_intr = 11'h5a5; ex_ecode = 6'h21;
    tick();
    exp_instret = exp_instret + 64'd1;
    chk("f_instr0", {32'd0, instr[0]}, 64'h12345678);
    chk("f_flags0", {60'd0, skip[0], tlbf[0], cnt[0], rstat[0]}, 64'hf);
    chk("f_tlbidx0", {59'd0, tlbidx[0]}, 64'd19);
    chk("f_timer0", timer[0], 64'hfedcba9876543210);
    chk("f_csrdata0", {32'd0, csrd[0]}, 64'h0badf00d);
    chk("f_storePaddr", storePaddr, 64'h0000000000001000);
    chk("f_storeVaddr", storeVaddr, 64'h0000000080001000);
    chk("f_storeData", storeData, 64'h00000000cafef00d);
    chk("f_storeIndex", {56'd0, storeIndex}, 64'd0);
    chk("f_eret_intr", {52'd0, eret, intrNo}, {52'd0, 1'b1, 11'h5a5});
    chk("f_excPC", {32'd0, exceptionPC}, 64'h1c000100);
    chk("f_excInst", {32'd0, exceptionInst}, 64'h002b0000);
    chk("f_instret", instret, exp_instret);
    idle_inputs();
    tick();
    chk("g_ivalid0", {63'd0, ivld[0]}, 64'd0);
    chk("g_instr0", {32'd0, instr[0]}, 64'd0);
    chk("g_timer0", timer[0], 64'd0);
    chk("g_storeValid", {56'd0, storeValid}, 64'd0);
    chk("g_storePaddr", storePaddr, 64'd0);
    chk("g_excp", {63'd0, excp_valid}, 64'd0);
    chk("g_excPC", {32'd0, exceptionPC}, 64'd0);

    // Watchdog with limit 8: seven idle cycles stay clear, eight set a sticky flag.
    cm_valid = 3'b001; tick(); exp_instret = exp_instret + 64'd1;
    idle_inputs();
    for (int c = 0; c < 7; c++) tick();
    chk("wd_idle7", {63'd0, hang}, 64'd0);
    cm_valid = 3'b001; tick(); exp_instret = exp_instret + 64'd1;
    chk("wd_commit_clears", {63'd0, hang}, 64'd0);
    idle_inputs();
    for (int c = 0; c < 7; c++) tick();
    chk("wd_idle7_again", {63'd0, hang}, 64'd0);
    tick();
    chk("wd_idle8", {63'd0, hang}, 64'd1);
    cm_valid = 3'b111; tick(); exp_instret = exp_instret + 64'd3;
    chk("wd_sticky", {63'd0, hang}, 64'd1);
    chk("wd_instret", instret, exp_instret);

    // Reset mid-burst clears everything at once; instret restarts from zero.
    tick();
    reset = 1'b0;
    #1;
    chk("mr_instret", instret, 64'd0);
    chk("mr_ivalid", {61'd0, ivld[2], ivld[1], ivld[0]}, 64'd0);
    chk("mr_pc0", pc[0], 64'd0);
    chk("mr_hang", {63'd0, hang}, 64'd0);
    chk("mr_index1", {56'd0, idx[1]}, 64'd0);
    @(negedge clock); idle_inputs(); reset = 1'b1;
    tick();
    chk("mr_after_instret", instret, 64'd0);
    chk("mr_after_ivalid", {61'd0, ivld[2], ivld[1], ivld[0]}, 64'd0);
    chk("mr_after_index2", {56'd0, idx[2]}, 64'd2);
    cm_valid = 3'b011; tick();
    chk("mr_restart_instret", instret, 64'd2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
